// File: rtl/decoder38_scan_if.sv
// decoder38_scan_if: handshake and output bundle for the 3-to-8 scan decoder.
// The master drives the code, enable and scan request. The slave (the
// decoder) returns the ready flag and the registered decoded outputs.
interface decoder38_scan_if;
  logic       iEn;
  logic       iValid;
  logic       oReady;
  logic [2:0] iData;
  logic       iScan;
  logic [7:0] oData;
  logic       oValid;
  logic [2:0] oIndex;

  modport master (
    output iEn, iValid, iData, iScan,
    input  oReady, oData, oValid, oIndex
  );

  modport slave (
    input  iEn, iValid, iData, iScan,
    output oReady, oData, oValid, oIndex
  );
endinterface

// File: rtl/decoder38_scan.sv
// decoder38_scan: registered 3-to-8 one-hot decoder with a valid/ready input
// handshake. It has an optional scan mode that walks the active line across
// all eight outputs, dwelling DIV clocks on each line.
// Define DECODER38_SCAN_EN to build the scan mode. Without it, the block is a
// plain registered decoder with enable, iScan is ignored and oReady is always 1.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs inactive, oValid=0, ready for a code
// HOLD  | showing the last accepted code, ready for a replacement
// SCAN  | self-running sweep of lines 0..7, not ready (scan build only)
module decoder38_scan #(
  parameter int unsigned DIV        = 4,    // scan dwell per line, 1..255
  parameter bit          ACTIVE_LOW = 1'b0  // 1: selected line driven low
) (
  input  logic            iClk,
  input  logic            iRst_n,
  decoder38_scan_if.slave bus
);

  localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [7:0] pattern(input logic [2:0] k);
    logic [7:0] onehot;
    onehot = 8'h01 << k;
    return ACTIVE_LOW ? ~onehot : onehot;
  endfunction

`ifdef DECODER38_SCAN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SCAN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t     state_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic [2:0] index_q;
  logic       accept;

`ifdef DECODER38_SCAN_EN
  localparam logic [7:0] DWELL_LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [2:0] index_d;
  logic       dwell_done;

  // The dwell counter runs 0..DIV-1. The index steps on the last count and
  // wraps from 7 back to 0 on its own.
  assign dwell_done = (cnt_q == DWELL_LAST);
  assign cnt_d      = dwell_done ? 8'd0 : cnt_q + 8'd1;
  assign index_d    = dwell_done ? index_q + 3'd1 : index_q;

  // Ready drops only once SCAN has been entered. So a valid arriving together
  // with the scan request sees ready=1, but it is not taken.
  assign bus.oReady = (state_q != SCAN);
`else
  assign bus.oReady = 1'b1;

  // These are not needed without the scan mode. They are gathered here so
  // that the intent to leave them unused is explicit.
  logic [10:0] unused_nonscan;
  assign unused_nonscan = {bus.iScan, state_q, 8'(DIV)};
`endif

  assign accept = bus.iEn && bus.iValid && bus.oReady;

  // FSM with registered outputs. The priority order is: disable, scan entry,
  // scan exit, scan stepping, and then the handshake.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
      index_q <= 3'd0;
`ifdef DECODER38_SCAN_EN
      cnt_q   <= 8'd0;
`endif
    end else if (!bus.iEn) begin
      state_q <= IDLE;
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
      index_q <= 3'd0;
`ifdef DECODER38_SCAN_EN
      cnt_q   <= 8'd0;
`endif
    end
`ifdef DECODER38_SCAN_EN
    else if (bus.iScan && state_q != SCAN) begin
      state_q <= SCAN;
      data_q  <= pattern(3'd0);
      valid_q <= 1'b1;
      index_q <= 3'd0;
      cnt_q   <= 8'd0;
    end else if (state_q == SCAN && !bus.iScan) begin
      state_q <= IDLE;
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
      index_q <= 3'd0;
      cnt_q   <= 8'd0;
    end else if (state_q == SCAN) begin
      cnt_q   <= cnt_d;
      index_q <= index_d;
      data_q  <= pattern(index_d);
    end
`endif
    else if (accept) begin
      state_q <= HOLD;
      data_q  <= pattern(bus.iData);
      valid_q <= 1'b1;
      index_q <= bus.iData;
    end
  end

  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;
  assign bus.oIndex = index_q;

endmodule

// File: tb/tb_decoder38_scan.sv
// tb_decoder38_scan: directed bench. Two decoders share the same stimulus,
// one with active-high outputs and one with active-low outputs, both with
// DIV=3. The scan checks are built only when DECODER38_SCAN_EN is defined.
// Otherwise the bench checks that iScan is ignored.
module tb_decoder38_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  decoder38_scan_if bus_h ();
  decoder38_scan_if bus_l ();

  assign bus_l.iEn    = bus_h.iEn;
  assign bus_l.iValid = bus_h.iValid;
  assign bus_l.iData  = bus_h.iData;
  assign bus_l.iScan  = bus_h.iScan;

  decoder38_scan #(.DIV(3), .ACTIVE_LOW(1'b0)) u_hi (
    .iClk(clk), .iRst_n(rst_n), .bus(bus_h)
  );
  decoder38_scan #(.DIV(3), .ACTIVE_LOW(1'b1)) u_lo (
    .iClk(clk), .iRst_n(rst_n), .bus(bus_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    bus_h.iEn    = 1'b0;
    bus_h.iValid = 1'b0;
    bus_h.iData  = 3'd0;
    bus_h.iScan  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_h.oData !== 8'h00) begin n_fail++; $display("FAIL reset_data_hi: got %h want 00", bus_h.oData); end
    n_checks++; if (bus_l.oData !== 8'hFF) begin n_fail++; $display("FAIL reset_data_lo: got %h want ff", bus_l.oData); end
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_h.oValid); end
    n_checks++; if (bus_h.oIndex !== 3'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", bus_h.oIndex); end
    n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_h.oReady); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", bus_h.oValid); end
  endtask

  task automatic test_walk();
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) begin
      bus_h.iEn    = 1'b1;
      bus_h.iValid = 1'b1;
      bus_h.iData  = 3'(k);
      tick();
      exp = 8'h01 << k;
      n_checks++; if (bus_h.oData !== exp) begin n_fail++; $display("FAIL walk_data_hi k=%0d: got %h want %h", k, bus_h.oData, exp); end
      n_checks++; if (bus_l.oData !== ~exp) begin n_fail++; $display("FAIL walk_data_lo k=%0d: got %h want %h", k, bus_l.oData, ~exp); end
      n_checks++; if (bus_h.oIndex !== 3'(k)) begin n_fail++; $display("FAIL walk_index k=%0d: got %0d want %0d", k, bus_h.oIndex, k); end
      n_checks++; if (bus_h.oValid !== 1'b1) begin n_fail++; $display("FAIL walk_valid k=%0d: got %b want 1", k, bus_h.oValid); end
    end
    bus_h.iValid = 1'b0;
  endtask

  task automatic test_hold_active_low();
    bus_h.iEn    = 1'b1;
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd5;
    tick();
    bus_h.iValid = 1'b0;
    bus_h.iData  = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (bus_l.oData !== 8'hDF) begin n_fail++; $display("FAIL hold_data_lo cyc=%0d: got %h want df", i, bus_l.oData); end
      n_checks++; if (bus_h.oData !== 8'h20) begin n_fail++; $display("FAIL hold_data_hi cyc=%0d: got %h want 20", i, bus_h.oData); end
      n_checks++; if (bus_l.oIndex !== 3'd5) begin n_fail++; $display("FAIL hold_index cyc=%0d: got %0d want 5", i, bus_l.oIndex); end
    end
    bus_h.iEn = 1'b0;
    tick();
    n_checks++; if (bus_l.oData !== 8'hFF) begin n_fail++; $display("FAIL disable_data_lo: got %h want ff", bus_l.oData); end
    n_checks++; if (bus_h.oData !== 8'h00) begin n_fail++; $display("FAIL disable_data_hi: got %h want 00", bus_h.oData); end
    n_checks++; if (bus_l.oValid !== 1'b0) begin n_fail++; $display("FAIL disable_valid: got %b want 0", bus_l.oValid); end
    n_checks++; if (bus_l.oIndex !== 3'd0) begin n_fail++; $display("FAIL disable_index: got %0d want 0", bus_l.oIndex); end
  endtask

  task automatic test_disable_with_valid();
    bus_h.iEn    = 1'b1;
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd1;
    tick();
    n_checks++; if (bus_h.oData !== 8'h02) begin n_fail++; $display("FAIL dis_pre_data: got %h want 02", bus_h.oData); end
    bus_h.iEn   = 1'b0;
    bus_h.iData = 3'd4;
    tick();
    n_checks++; if (bus_h.oData !== 8'h00) begin n_fail++; $display("FAIL dis_valid_data: got %h want 00", bus_h.oData); end
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL dis_valid_valid: got %b want 0", bus_h.oValid); end
    n_checks++; if (bus_h.oIndex !== 3'd0) begin n_fail++; $display("FAIL dis_valid_index: got %0d want 0", bus_h.oIndex); end
    bus_h.iEn    = 1'b1;
    bus_h.iValid = 1'b0;
    tick();
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL idle_no_accept_valid: got %b want 0", bus_h.oValid); end
    n_checks++; if (bus_l.oData !== 8'hFF) begin n_fail++; $display("FAIL idle_no_accept_data: got %h want ff", bus_l.oData); end
  endtask

`ifdef DECODER38_SCAN_EN
  task automatic test_scan();
    logic [7:0] exp;
    int         idx;
    bus_h.iEn    = 1'b1;
    bus_h.iScan  = 1'b1;
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd6;
    #1;
    n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL scan_entry_ready: got %b want 1", bus_h.oReady); end
    for (int c = 0; c < 30; c++) begin
      tick();
      idx = (c / 3) % 8;
      exp = 8'h01 << idx;
      n_checks++; if (bus_h.oIndex !== 3'(idx)) begin n_fail++; $display("FAIL scan_index c=%0d: got %0d want %0d", c, bus_h.oIndex, idx); end
      n_checks++; if (bus_h.oData !== exp) begin n_fail++; $display("FAIL scan_data c=%0d: got %h want %h", c, bus_h.oData, exp); end
      n_checks++; if (bus_l.oData !== ~exp) begin n_fail++; $display("FAIL scan_data_lo c=%0d: got %h want %h", c, bus_l.oData, ~exp); end
      n_checks++; if (bus_h.oReady !== 1'b0) begin n_fail++; $display("FAIL scan_ready c=%0d: got %b want 0", c, bus_h.oReady); end
      n_checks++; if (bus_h.oValid !== 1'b1) begin n_fail++; $display("FAIL scan_valid c=%0d: got %b want 1", c, bus_h.oValid); end
    end
    bus_h.iScan  = 1'b0;
    bus_h.iValid = 1'b0;
    tick();
    n_checks++; if (bus_h.oData !== 8'h00) begin n_fail++; $display("FAIL scan_exit_data: got %h want 00", bus_h.oData); end
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL scan_exit_valid: got %b want 0", bus_h.oValid); end
    n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL scan_exit_ready: got %b want 1", bus_h.oReady); end
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd2;
    tick();
    bus_h.iValid = 1'b0;
    n_checks++; if (bus_h.oData !== 8'h04) begin n_fail++; $display("FAIL post_scan_accept: got %h want 04", bus_h.oData); end
  endtask
`else
  task automatic test_scan_ignored();
    bus_h.iEn    = 1'b1;
    bus_h.iScan  = 1'b1;
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd3;
    tick();
    bus_h.iValid = 1'b0;
    n_checks++; if (bus_h.oData !== 8'h08) begin n_fail++; $display("FAIL noscan_data: got %h want 08", bus_h.oData); end
    n_checks++; if (bus_h.oIndex !== 3'd3) begin n_fail++; $display("FAIL noscan_index: got %0d want 3", bus_h.oIndex); end
    n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL noscan_ready: got %b want 1", bus_h.oReady); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_l.oData !== 8'hF7) begin n_fail++; $display("FAIL noscan_hold cyc=%0d: got %h want f7", i, bus_l.oData); end
      n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL noscan_hold_ready cyc=%0d: got %b want 1", i, bus_h.oReady); end
    end
    bus_h.iScan = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bus_h.iEn    = 1'b1;
    bus_h.iValid = 1'b1;
    bus_h.iData  = 3'd7;
    tick();
    bus_h.iValid = 1'b0;
    n_checks++; if (bus_h.oData !== 8'h80) begin n_fail++; $display("FAIL midrst_pre: got %h want 80", bus_h.oData); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_h.oData !== 8'h00) begin n_fail++; $display("FAIL midrst_data_hi: got %h want 00", bus_h.oData); end
    n_checks++; if (bus_l.oData !== 8'hFF) begin n_fail++; $display("FAIL midrst_data_lo: got %h want ff", bus_l.oData); end
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus_h.oValid); end
    n_checks++; if (bus_h.oIndex !== 3'd0) begin n_fail++; $display("FAIL midrst_index: got %0d want 0", bus_h.oIndex); end
    n_checks++; if (bus_h.oReady !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus_h.oReady); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus_h.oValid !== 1'b0) begin n_fail++; $display("FAIL midrst_release_valid: got %b want 0", bus_h.oValid); end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_hold_active_low();
    test_disable_with_valid();
`ifdef DECODER38_SCAN_EN
    test_scan();
`else
    test_scan_ignored();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
